// File: rtl/aes_round_sequencer_pkg.sv
// Shared types and helpers for the AES-128 round sequencer.
// Blocks use FIPS-197 byte order: byte 0 in [127:120], bytes run column-major.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 128;
    localparam int NUM_COLS   = 4;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_ADD0  = 2'd1,
        FSM_ROUND = 2'd2,
        FSM_DONE  = 2'd3
    } fsm_e;

    localparam logic [1:0] ST_IDLE  = FSM_IDLE;
    localparam logic [1:0] ST_ADD0  = FSM_ADD0;
    localparam logic [1:0] ST_ROUND = FSM_ROUND;
    localparam logic [1:0] ST_DONE  = FSM_DONE;

    // Byte (row, col) lives at index 4*col + row.
    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [1:0] row,
                                            input logic [1:0] col);
        int unsigned idx;
        idx = {28'd0, col, row};
        return blk[BLOCK_W-1-8*idx -: 8];
    endfunction

    function automatic logic [WORD_W-1:0] get_col(input logic [BLOCK_W-1:0] blk,
                                                  input logic [1:0] col);
        int unsigned c;
        c = {30'd0, col};
        return blk[BLOCK_W-1-WORD_W*c -: WORD_W];
    endfunction

    function automatic logic [BLOCK_W-1:0] set_col(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0] col,
                                                   input logic [WORD_W-1:0] word);
        logic [BLOCK_W-1:0] res;
        res = blk;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col == 2'(c)) res[BLOCK_W-1-WORD_W*c -: WORD_W] = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Column-serial AES-128 encryption sequencer: one state column per cycle, with
// SubBytes/MixColumns and the key schedule provided by external combinational stages.
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic [3:0]   rk_round,
    output logic [1:0]   rk_col,
    input  logic [31:0]  rk_word,
    output logic [31:0]  smix_word,
    output logic [1:0]   smix_index,
    output logic         smix_last,
    input  logic [31:0]  smix_out
);

    logic [1:0]         fsm_q, fsm_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] nxt_q, nxt_d;
    logic [3:0]         round_q, round_d;
    logic [1:0]         col_q, col_d;
    logic [WORD_W-1:0]  gather;
    logic               in_add0, in_round;

    assign in_add0  = (fsm_q == ST_ADD0);
    assign in_round = (fsm_q == ST_ROUND);

    // ShiftRows folded into the read: row r of output column j comes from column j+r.
    always_comb begin
        gather = '0;
        for (int r = 0; r < 4; r++) begin
            gather[WORD_W-1-8*r -: 8] = get_byte(blk_q, 2'(r), col_q + 2'(r));
        end
    end

    assign in_ready   = (fsm_q == ST_IDLE);
    assign out_valid  = (fsm_q == ST_DONE);
    assign out_data   = out_valid ? blk_q : '0;
    assign rk_round   = (in_add0 || in_round) ? round_q : 4'd0;
    assign rk_col     = (in_add0 || in_round) ? col_q : 2'd0;
    assign smix_word  = in_round ? gather : '0;
    assign smix_index = in_round ? col_q : 2'd0;
    assign smix_last  = in_round && (round_q == 4'(NUM_ROUNDS));

    always_comb begin
        fsm_d   = fsm_q;
        blk_d   = blk_q;
        nxt_d   = nxt_q;
        round_d = round_q;
        col_d   = col_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    blk_d   = in_data;
                    round_d = 4'd0;
                    col_d   = 2'd0;
                    fsm_d   = ST_ADD0;
                end
            end
            ST_ADD0: begin
                blk_d = set_col(blk_q, col_q, get_col(blk_q, col_q) ^ rk_word);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    round_d = 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // Results go to a side buffer so later columns still gather the old state.
                nxt_d = set_col(nxt_q, col_q, smix_out ^ rk_word);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    blk_d = nxt_d;
                    if (round_q == 4'(NUM_ROUNDS)) begin
                        round_d = 4'd0;
                        fsm_d   = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            blk_q   <= '0;
            nxt_q   <= '0;
            round_q <= 4'd0;
            col_q   <= 2'd0;
        end else begin
            fsm_q   <= fsm_d;
            blk_q   <= blk_d;
            nxt_q   <= nxt_d;
            round_q <= round_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: FIPS-197 vectors through a reference SMIX stage and key schedule.
module tb_aes_round_sequencer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic [3:0]   rk_round;
    logic [1:0]   rk_col;
    logic [31:0]  rk_word;
    logic [31:0]  smix_word;
    logic [1:0]   smix_index;
    logic         smix_last;
    logic [31:0]  smix_out;

    logic [63:0][31:0] rk_w;
    int n_checks = 0;
    int n_fail   = 0;

    aes_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .rk_round   (rk_round),
        .rk_col     (rk_col),
        .rk_word    (rk_word),
        .smix_word  (smix_word),
        .smix_index (smix_index),
        .smix_last  (smix_last),
        .smix_out   (smix_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference GF(2^8) arithmetic.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] e;
        e = 8'hfe;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, a);
        end
        if (a == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] smix_model(input logic [31:0] w, input logic last);
        logic [7:0] s0, s1, s2, s3;
        s0 = sbox(w[31:24]);
        s1 = sbox(w[23:16]);
        s2 = sbox(w[15:8]);
        s3 = sbox(w[7:0]);
        if (last) return {s0, s1, s2, s3};
        return {gmul(s0, 8'h02) ^ gmul(s1, 8'h03) ^ s2 ^ s3,
                s0 ^ gmul(s1, 8'h02) ^ gmul(s2, 8'h03) ^ s3,
                s0 ^ s1 ^ gmul(s2, 8'h02) ^ gmul(s3, 8'h03),
                gmul(s0, 8'h03) ^ s1 ^ s2 ^ gmul(s3, 8'h02)};
    endfunction

    assign smix_out = smix_model(smix_word, smix_last);
    assign rk_word  = rk_w[{rk_round, rk_col}];

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        rk_w = '0;
        for (int i = 0; i < 44; i++) rk_w[i] = w[i];
    endtask

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Feeds one block, checks the per-cycle request sequence, latency, result and
    // output hold under backpressure, then completes the output handshake.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] expct, input bit keep_valid, input int bp);
        int edges;
        expand_key(key);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = pt;
        out_ready = 1'b0;
        check_eq("in_ready_idle", 128'(in_ready), 128'(1));
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 60) begin
            check_eq("rk_round", 128'(rk_round), 128'(edges < 4 ? 0 : (edges - 4) / 4 + 1));
            check_eq("rk_col", 128'(rk_col), 128'(edges % 4));
            check_eq("smix_index", 128'(smix_index), 128'(edges < 4 ? 0 : edges % 4));
            check_eq("smix_last", 128'(smix_last), 128'(edges >= 40 ? 1 : 0));
            check_eq("in_ready_busy", 128'(in_ready), 128'(0));
            if (keep_valid) in_data = {$urandom, $urandom, $urandom, $urandom};
            else in_valid = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("latency", 128'(edges), 128'(44));
        check_eq("out_valid", 128'(out_valid), 128'(1));
        check_eq("out_data", out_data, expct);
        check_eq("smix_word_done", 128'(smix_word), 128'(0));
        for (int i = 0; i < bp; i++) begin
            if (keep_valid) in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_eq("bp_out_data", out_data, expct);
            check_eq("bp_in_ready", 128'(in_ready), 128'(0));
            check_eq("bp_out_valid", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("idle_out_valid", 128'(out_valid), 128'(0));
        check_eq("idle_in_ready", 128'(in_ready), 128'(1));
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        int waited;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rk_w      = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_out_data", out_data, 128'(0));
        check_eq("rst_rk_round", 128'(rk_round), 128'(0));
        check_eq("rst_rk_col", 128'(rk_col), 128'(0));
        check_eq("rst_smix_word", 128'(smix_word), 128'(0));
        check_eq("rst_smix_index", 128'(smix_index), 128'(0));
        check_eq("rst_smix_last", 128'(smix_last), 128'(0));
        rst = 1'b0;

        run_block(KEY_B, PT_B, CT_B, 1'b0, 0);
        run_block(KEY_C, PT_C, CT_C, 1'b0, 20);
        run_block(KEY_C, PT_C, CT_C, 1'b1, 3);

        // Abort mid-block at round 5, column 2.
        expand_key(KEY_B);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = PT_C;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!(rk_round == 4'd5 && rk_col == 2'd2) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("reach_r5c2", 128'(waited < 100), 128'(1));
        #1 rst = 1'b1;
        #1;
        check_eq("abort_in_ready", 128'(in_ready), 128'(1));
        check_eq("abort_out_valid", 128'(out_valid), 128'(0));
        check_eq("abort_rk_round", 128'(rk_round), 128'(0));
        check_eq("abort_smix_word", 128'(smix_word), 128'(0));
        @(negedge clk);
        check_eq("abort_next_in_ready", 128'(in_ready), 128'(1));
        check_eq("abort_next_out_valid", 128'(out_valid), 128'(0));
        check_eq("abort_out_data", out_data, 128'(0));
        rst = 1'b0;
        run_block(KEY_B, PT_B, CT_B, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-016: name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  plaintext block offered.
REQ-005 in_data  in  128  plaintext, FIPS-197 byte order (byte 0 = [127:120], column-major).
REQ-006 in_ready  out  1  block can accept plaintext.
REQ-007 out_valid  out  1  ciphertext available.
REQ-008 out_data  out  128  ciphertext, same byte order.
REQ-009 out_ready  in  1  consumer accepts ciphertext.
REQ-010 rk_round  out  4  round-key round number requested (0..10).
REQ-011 rk_col  out  2  round-key word (column) requested.
REQ-012 rk_word  in  32  round-key word; combinational same-cycle response to rk_round/rk_col.
REQ-013 smix_word  out  32  ShiftRows-gathered column to the SMIX stage.
REQ-014 smix_index  out  2  output column index j to SMIX.
REQ-015 smix_last  out  1  high during round 10 (SMIX skips MixColumns).
REQ-016 smix_out  in  32  SMIX result; combinational, same cycle.

Function
REQ-017 The FSM SHALL have states IDLE, ADD0, ROUND, DONE.
REQ-018 in_ready SHALL be 1 exactly in IDLE; acceptance = in_valid & in_ready at a rising edge, loading in_data into the state register, col=0, round=0, going to ADD0.
REQ-019 ADD0 SHALL take 4 cycles; cycle j: state column j ^= rk_word with rk_round=0, rk_col=j.
REQ-020 After column 3 of ADD0, FSM SHALL go to ROUND with round=1, col=0.
REQ-021 ROUND cycle j SHALL drive smix_word byte r (bits [31-8r -:8]) = state byte (row r, column (j+r) mod 4), smix_index=j, smix_last=(round==10), rk_round=round, rk_col=j.
REQ-022 ROUND cycle j SHALL write smix_out ^ rk_word into column j of a separate next-state buffer; the state register SHALL stay unchanged until column 3.
REQ-023 At column 3, next-state (with column 3 result) SHALL be committed to state; round increments, col wraps to 0.
REQ-024 After round 10 commit, FSM SHALL go to DONE; out_valid=1, out_data=state.
REQ-025 Latency: out_valid SHALL rise exactly 44 rising edges after the accepting edge.
REQ-026 In DONE, out_data SHALL hold stable until out_valid & out_ready; then FSM SHALL go to IDLE (in_ready=1 next cycle, no same-cycle reaccept).
REQ-027 in_valid in non-IDLE states SHALL be ignored; in_data is sampled only on acceptance.
REQ-028 Outside ADD0/ROUND, rk_round, rk_col, smix_index, smix_last SHALL be 0 and smix_word SHALL be 0.
REQ-029 Round counter SHALL never exceed 10; col counter is 2-bit, wrapping 3->0.

Reset
REQ-030 On rst (any time, incl. mid-round or DONE) FSM SHALL enter IDLE immediately; state, next-state, round, col cleared to 0.
REQ-031 Reset values: in_ready=1, out_valid=0, out_data=0, rk_round=0, rk_col=0, smix_*=0.
REQ-032 An in-progress block interrupted by reset SHALL be discarded; no partial out_valid.

Structure
REQ-033 Package aes_pkg SHALL hold the FSM state enum, NUM_ROUNDS=10, WORD_W=32, BLOCK_W=128 and byte/column index helpers.
REQ-034 SMIX SHALL stay an external stage wired at the parent; no sub-module inside this block; key expansion is external.

Verification
REQ-035 Bench SHALL model SMIX (SubBytes+MixColumns, no Mix when last) and a FIPS-197 key schedule serving rk_word.
REQ-036 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid 44 edges after accept.
REQ-037 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-038 Backpressure: out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-039 Reset at round 5, column 2 -> next cycle in_ready=1, out_valid=0; new App.B block then encrypts correctly.
REQ-040 in_valid held high with changing in_data during processing -> result matches only the data accepted in IDLE; rk_round sequence 0,0,0,0,1,1,1,1,...,10.
